// File: rtl/enemy_controller.sv
// Enemy movement and attack engine: move-rate divider, lane position and attack FSM.
// The lane comes from the LFSR request on each MOVE tick; x_out follows one clock later.
module enemy_controller #(
   parameter int NUM_LANES    = 3,
   parameter int LANE_W       = 2,
   parameter int X_BASE       = 20,
   parameter int X_STEP       = 40,
   parameter int Y_POS        = 8,
   parameter int DIV_W        = 28,
   parameter int SLOW_DIV     = 100000000,
   parameter int FAST_DIV     = 50000000,
   parameter int MOVES_N      = 4,
   parameter int WINDUP_TICKS = 2,
   parameter int STRIKE_CYC   = 8
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              enable,
   input  logic              speed,
   input  logic              aggressive,
   input  logic [LANE_W-1:0] lane_req,
   input  logic              block_in,
   output logic [7:0]        x_out,
   output logic [6:0]        y_out,
   output logic              tick,
   output logic [2:0]        state_out,
   output logic              attack_out,
   output logic              hit_pulse,
   output logic              blocked_pulse
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_MOVE    = 3'd1,
      ST_WINDUP  = 3'd2,
      ST_STRIKE  = 3'd3,
      ST_RECOVER = 3'd4
   } state_t;

   localparam int MOVES_AGG = (MOVES_N / 2 < 1) ? 1 : MOVES_N / 2;
   localparam int MOVE_W    = $clog2(MOVES_N + 1);
   localparam int PHASE_MAX = (WINDUP_TICKS > STRIKE_CYC) ? WINDUP_TICKS : STRIKE_CYC;
   localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

   localparam logic [DIV_W-1:0]   SLOW_RELOAD   = DIV_W'(SLOW_DIV - 1);
   localparam logic [DIV_W-1:0]   FAST_RELOAD   = DIV_W'(FAST_DIV - 1);
   localparam logic [MOVE_W-1:0]  MOVE_LIM_NORM = MOVE_W'(MOVES_N);
   localparam logic [MOVE_W-1:0]  MOVE_LIM_AGG  = MOVE_W'(MOVES_AGG);
   localparam logic [PHASE_W-1:0] WINDUP_LAST   = PHASE_W'(WINDUP_TICKS - 1);
   localparam logic [PHASE_W-1:0] STRIKE_LAST   = PHASE_W'(STRIKE_CYC - 1);
   localparam logic [LANE_W:0]    LANE_LIMIT    = (LANE_W + 1)'(NUM_LANES);
   localparam logic [7:0]         X_BASE_V      = 8'(X_BASE);
   localparam logic [7:0]         X_STEP_V      = 8'(X_STEP);

   state_t             state_reg;
   logic [DIV_W-1:0]   div_cnt_reg;
   logic               tick_reg;
   logic [LANE_W-1:0]  lane_reg;
   logic [MOVE_W-1:0]  move_cnt_reg;
   logic [PHASE_W-1:0] phase_cnt_reg;
   logic               blocked_flag_reg;
   logic               attack_reg;
   logic               hit_reg;
   logic               blocked_reg;
   logic [7:0]         x_reg;

   logic [MOVE_W-1:0]  move_cnt_next;
   logic [MOVE_W-1:0]  move_limit;
   logic               lane_ok;
   logic [7:0]         x_next;

   assign tick          = tick_reg & enable;
   assign move_cnt_next = move_cnt_reg + 1'b1;
   assign move_limit    = aggressive ? MOVE_LIM_AGG : MOVE_LIM_NORM;
   assign lane_ok       = {1'b0, lane_req} < LANE_LIMIT;
   assign x_next        = X_BASE_V + 8'(lane_reg) * X_STEP_V;

   // Speed is only consulted at reload, so a change never truncates the running period.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         div_cnt_reg <= '0;
         tick_reg    <= 1'b0;
      end else if (enable) begin
         if (div_cnt_reg == '0) begin
            tick_reg    <= 1'b1;
            div_cnt_reg <= speed ? FAST_RELOAD : SLOW_RELOAD;
         end else begin
            tick_reg    <= 1'b0;
            div_cnt_reg <= div_cnt_reg - 1'b1;
         end
      end else begin
         tick_reg <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_reg        <= ST_IDLE;
         lane_reg         <= '0;
         move_cnt_reg     <= '0;
         phase_cnt_reg    <= '0;
         blocked_flag_reg <= 1'b0;
         attack_reg       <= 1'b0;
         hit_reg          <= 1'b0;
         blocked_reg      <= 1'b0;
         x_reg            <= X_BASE_V;
      end else begin
         hit_reg     <= 1'b0;
         blocked_reg <= 1'b0;
         x_reg       <= x_next;
         case (state_reg)
            ST_IDLE: begin
               if (enable) state_reg <= ST_MOVE;
            end
            ST_MOVE: begin
               if (tick) begin
                  if (lane_ok) lane_reg <= lane_req;
                  if (move_cnt_next >= move_limit) begin
                     move_cnt_reg <= '0;
                     state_reg    <= ST_WINDUP;
                  end else begin
                     move_cnt_reg <= move_cnt_next;
                  end
               end
            end
            ST_WINDUP: begin
               if (tick) begin
                  if (phase_cnt_reg == WINDUP_LAST) begin
                     phase_cnt_reg <= '0;
                     attack_reg    <= 1'b1;
                     state_reg     <= ST_STRIKE;
                  end else begin
                     phase_cnt_reg <= phase_cnt_reg + 1'b1;
                  end
               end
            end
            // Counted on raw clocks and ignores enable so a strike always completes.
            ST_STRIKE: begin
               if (phase_cnt_reg == STRIKE_LAST) begin
                  phase_cnt_reg    <= '0;
                  attack_reg       <= 1'b0;
                  hit_reg          <= ~(blocked_flag_reg | block_in);
                  blocked_reg      <= blocked_flag_reg | block_in;
                  blocked_flag_reg <= 1'b0;
                  state_reg        <= ST_RECOVER;
               end else begin
                  phase_cnt_reg <= phase_cnt_reg + 1'b1;
                  if (block_in) blocked_flag_reg <= 1'b1;
               end
            end
            ST_RECOVER: begin
               if (tick) state_reg <= ST_MOVE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign x_out         = x_reg;
   assign y_out         = 7'(Y_POS);
   assign state_out     = state_reg;
   assign attack_out    = attack_reg;
   assign hit_pulse     = hit_reg;
   assign blocked_pulse = blocked_reg;

endmodule

// File: tb/tb_enemy_controller.sv
// Randomised scoreboard bench for enemy_controller: a tick/phase-level model predicts
// every visible event (tick, state change, attack edge, hit/blocked pulse).
module tb_enemy_controller;

   localparam int SLOW  = 4;
   localparam int FAST  = 2;
   localparam int NL    = 3;
   localparam int XB    = 20;
   localparam int XS    = 40;
   localparam int YP    = 8;
   localparam int MOVES = 4;
   localparam int WIND  = 2;
   localparam int SCYC  = 8;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       enable = 1'b0;
   logic       speed = 1'b0;
   logic       aggressive = 1'b0;
   logic       block_in = 1'b0;
   logic [1:0] lane_req = 2'd0;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic       tick;
   logic [2:0] state_out;
   logic       attack_out;
   logic       hit_pulse;
   logic       blocked_pulse;

   enemy_controller #(
      .NUM_LANES(NL), .LANE_W(2), .X_BASE(XB), .X_STEP(XS), .Y_POS(YP), .DIV_W(8),
      .SLOW_DIV(SLOW), .FAST_DIV(FAST), .MOVES_N(MOVES), .WINDUP_TICKS(WIND), .STRIKE_CYC(SCYC)
   ) dut (
      .clock(clock), .resetn(resetn), .enable(enable), .speed(speed), .aggressive(aggressive),
      .lane_req(lane_req), .block_in(block_in), .x_out(x_out), .y_out(y_out), .tick(tick),
      .state_out(state_out), .attack_out(attack_out), .hit_pulse(hit_pulse),
      .blocked_pulse(blocked_pulse)
   );

   always #5 clock = ~clock;

   typedef struct {
      int cyc;
      bit tk;
      bit hit;
      bit blk;
      int st;
      int x;
      bit att;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // Reference model: clocks-until-tick, phase number, lane, and per-phase tick/clock counts.
   int m_div, m_ph, m_lane, m_x, m_moves, m_wind, m_left, p_ph;
   bit m_tick, m_flag, m_att, m_hit, m_blkp, p_att;
   int move_ticks = 0;

   bit nx_rst, nx_en, nx_spd, nx_agg, nx_blk;
   int nx_lane;

   int lane_seq[4] = '{2, 1, 3, 0};
   int x_tab[4]    = '{100, 60, 60, 20};

   task automatic m_reset();
      m_div = 0; m_tick = 0; m_ph = 0; m_lane = 0; m_x = XB;
      m_moves = 0; m_wind = 0; m_left = 0; m_flag = 0;
      m_att = 0; m_hit = 0; m_blkp = 0; p_ph = 0; p_att = 0;
   endtask

   task automatic model_step();
      bit t;
      int lim;
      t = m_tick && enable;
      m_hit = 0;
      m_blkp = 0;
      m_x = XB + m_lane * XS;
      if (enable) begin
         if (m_div == 0) begin
            m_tick = 1;
            m_div = (speed ? FAST : SLOW) - 1;
         end else begin
            m_tick = 0;
            m_div--;
         end
      end else begin
         m_tick = 0;
      end
      case (m_ph)
         0: if (enable) m_ph = 1;
         1: if (t) begin
            if (int'(lane_req) < NL) m_lane = int'(lane_req);
            m_moves++;
            move_ticks++;
            lim = aggressive ? ((MOVES / 2 < 1) ? 1 : MOVES / 2) : MOVES;
            if (m_moves >= lim) begin
               m_moves = 0;
               m_ph = 2;
            end
         end
         2: if (t) begin
            m_wind++;
            if (m_wind == WIND) begin
               m_wind = 0;
               m_ph = 3;
               m_left = SCYC;
               m_att = 1;
            end
         end
         3: begin
            m_flag = m_flag | block_in;
            m_left--;
            if (m_left == 0) begin
               m_att = 0;
               if (m_flag) m_blkp = 1;
               else m_hit = 1;
               m_flag = 0;
               m_ph = 4;
            end
         end
         4: if (t) m_ph = 1;
         default: ;
      endcase
   endtask

   task automatic push_expect();
      exp_t e;
      bit vt;
      vt = m_tick && enable;
      if (vt || m_hit || m_blkp || (m_att != p_att) || (m_ph != p_ph)) begin
         e.cyc = cyc; e.tk = vt; e.hit = m_hit; e.blk = m_blkp;
         e.st = m_ph; e.x = m_x; e.att = m_att;
         exp_q.push_back(e);
      end
      p_att = m_att;
      p_ph = m_ph;
   endtask

   task automatic run_cycle();
      @(posedge clock);
      cyc++;
      if (resetn) model_step();
      #1;
      resetn = nx_rst; enable = nx_en; speed = nx_spd; aggressive = nx_agg;
      block_in = nx_blk; lane_req = 2'(nx_lane);
      if (resetn) push_expect();
   endtask

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end else begin
         $display("check %s: %0d ok", name, act);
      end
   endtask

   task automatic random_inputs();
      nx_lane = int'($urandom_range(0, 3));
      nx_blk = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 39) == 0) nx_spd = ~nx_spd;
      if ($urandom_range(0, 29) == 0) nx_agg = ~nx_agg;
      if (nx_en && $urandom_range(0, 49) == 0) nx_en = 0;
      else if (!nx_en && $urandom_range(0, 5) == 0) nx_en = 1;
   endtask

   // Monitor: every DUT event is matched against the oldest predicted event.
   initial begin
      bit p_att_d;
      logic [2:0] p_st_d;
      bit ev;
      exp_t e;
      p_att_d = 0;
      p_st_d = 3'd0;
      forever begin
         @(negedge clock);
         if (resetn) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
               e = exp_q.pop_front();
               checks++;
               errors++;
               $display("FAIL event cyc %0d: no DUT event, expected tick=%0b hit=%0b blk=%0b st=%0d x=%0d att=%0b",
                        e.cyc, e.tk, e.hit, e.blk, e.st, e.x, e.att);
            end
            ev = tick || hit_pulse || blocked_pulse || (attack_out != p_att_d) || (state_out != p_st_d);
            if (ev) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL event cyc %0d: unexpected tick=%0b hit=%0b blk=%0b st=%0d x=%0d att=%0b, expected no event",
                           cyc, tick, hit_pulse, blocked_pulse, state_out, x_out, attack_out);
               end else begin
                  e = exp_q.pop_front();
                  if (e.cyc != cyc || e.tk != tick || e.hit != hit_pulse || e.blk != blocked_pulse ||
                      e.st != int'(state_out) || e.x != int'(x_out) || e.att != attack_out ||
                      int'(y_out) != YP) begin
                     errors++;
                     $display("FAIL event cyc %0d: got tick=%0b hit=%0b blk=%0b st=%0d x=%0d att=%0b y=%0d, expected cyc %0d tick=%0b hit=%0b blk=%0b st=%0d x=%0d att=%0b y=%0d",
                              cyc, tick, hit_pulse, blocked_pulse, state_out, x_out, attack_out, y_out,
                              e.cyc, e.tk, e.hit, e.blk, e.st, e.x, e.att, YP);
                  end else begin
                     $display("event cyc %0d: tick=%0b hit=%0b blk=%0b st=%0d x=%0d att=%0b ok",
                              cyc, tick, hit_pulse, blocked_pulse, state_out, x_out, attack_out);
                  end
               end
            end
         end
         p_att_d = attack_out;
         p_st_d = state_out;
      end
   end

   initial begin
      int mt_before;
      int chk_idx;
      bit found;
      m_reset();
      nx_rst = 0; nx_en = 0; nx_spd = 0; nx_agg = 0; nx_blk = 0; nx_lane = 0;
      repeat (2) run_cycle();
      nx_en = 1;
      run_cycle();
      check("reset_x", int'(x_out), XB);
      check("reset_y", int'(y_out), YP);
      check("reset_state", int'(state_out), 0);
      check("reset_tick", int'(tick), 0);
      check("reset_attack", int'(attack_out), 0);
      check("reset_hit", int'(hit_pulse), 0);
      check("reset_blocked", int'(blocked_pulse), 0);

      // Directed lane sequence 2,1,3,0 at slow speed; 3 is out of range and must be ignored.
      nx_rst = 1;
      chk_idx = 0;
      for (int i = 0; i < 40; i++) begin
         nx_lane = lane_seq[move_ticks % 4];
         mt_before = move_ticks;
         run_cycle();
         if (chk_idx > 0) begin
            check($sformatf("lane_x_%0d", chk_idx), int'(x_out), x_tab[chk_idx - 1]);
            chk_idx = 0;
         end
         if (move_ticks != mt_before && move_ticks <= 4) begin
            chk_idx = move_ticks;
            if (move_ticks == 4) check("windup_after_4_moves", int'(state_out), 2);
         end
      end

      for (int i = 0; i < 700; i++) begin
         random_inputs();
         run_cycle();
      end

      // Block for one cycle inside a strike, then drop enable before it ends.
      nx_en = 1; nx_blk = 0;
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         nx_lane = int'($urandom_range(0, 3));
         run_cycle();
         if (m_ph == 3) found = 1;
      end
      check("strike_reached_a", int'(found), 1);
      nx_blk = 1;
      run_cycle();
      nx_blk = 0;
      run_cycle();
      nx_en = 0;
      repeat (25) run_cycle();
      check("freeze_in_recover", int'(state_out), 4);
      check("frozen_tick", int'(tick), 0);
      nx_en = 1;

      // Reset asserted asynchronously during strike cycle 3.
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         nx_lane = int'($urandom_range(0, 3));
         run_cycle();
         if (m_ph == 3 && m_left == SCYC - 2) found = 1;
      end
      check("strike_reached_b", int'(found), 1);
      check("attack_before_reset", int'(attack_out), 1);
      #1;
      resetn = 0;
      nx_rst = 0;
      exp_q.delete();
      m_reset();
      #1;
      check("async_attack", int'(attack_out), 0);
      check("async_x", int'(x_out), XB);
      check("async_state", int'(state_out), 0);
      check("async_hit", int'(hit_pulse), 0);
      check("async_blocked", int'(blocked_pulse), 0);
      repeat (2) run_cycle();
      nx_rst = 1;
      run_cycle();
      check("post_reset_hit", int'(hit_pulse), 0);
      check("post_reset_blocked", int'(blocked_pulse), 0);
      for (int i = 0; i < 80; i++) begin
         random_inputs();
         run_cycle();
      end
      @(negedge clock);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/enemy_controller.md
Name: enemy_controller

Overview:
- Parametrised enemy movement and attack engine for the boxing game.
- Drives the enemy sprite's x/y coordinates across N lanes at a selectable tick rate.
- Runs an attack state machine (move, wind-up, strike, recover) and reports hit/blocked outcomes to the game FSM.
- Lane choice comes from the external LFSR; `tick` is returned to the LFSR as its enable.

Parameters:
- NUM_LANES, 3, number of lanes (2..8).
- LANE_W, 2, lane index width; must satisfy 2^LANE_W >= NUM_LANES.
- X_BASE, 20, x coordinate of lane 0.
- X_STEP, 40, x spacing between lanes. X_BASE + (NUM_LANES-1)*X_STEP must be <= 255.
- Y_POS, 8, constant y coordinate (7 bits).
- DIV_W, 28, divider counter width.
- SLOW_DIV, 100000000, clocks per tick when speed=0.
- FAST_DIV, 50000000, clocks per tick when speed=1.
- MOVES_N, 4, ticks spent in MOVE before a wind-up when aggressive=0. Aggressive mode uses MOVES_N/2, minimum 1.
- WINDUP_TICKS, 2, ticks spent in WINDUP.
- STRIKE_CYC, 8, clock cycles attack_out is held high.

Ports:
- clock, in, 1, system clock.
- resetn, in, 1, asynchronous active-low reset.
- enable, in, 1, run/freeze control.
- speed, in, 1, 0 = SLOW_DIV, 1 = FAST_DIV.
- aggressive, in, 1, shortens the MOVE phase.
- lane_req, in, LANE_W, next lane requested by the LFSR.
- block_in, in, 1, player is blocking.
- x_out, out, 8, enemy x coordinate.
- y_out, out, 7, enemy y coordinate (always Y_POS).
- tick, out, 1, one-cycle move-rate pulse.
- state_out, out, 3, encoded FSM state.
- attack_out, out, 1, strike active.
- hit_pulse, out, 1, one-cycle pulse: strike landed.
- blocked_pulse, out, 1, one-cycle pulse: strike was blocked.

Behaviour:

Reset (asynchronous, resetn=0):
- lane = 0, so x_out = X_BASE.
- Divider count = 0.
- move_cnt = 0, phase_cnt = 0, blocked_flag = 0.
- FSM = IDLE.
- tick, attack_out, hit_pulse, blocked_pulse = 0.

Divider:
- Down-counter. When enable=1 and count=0: tick=1 for one cycle and count reloads to (period-1). Otherwise count decrements.
- period is selected by the current value of speed.
- A change of speed takes effect at the next reload; the current count is not truncated.
- enable=0 freezes the count and forces tick=0.

FSM states and encoding: IDLE=0, MOVE=1, WINDUP=2, STRIKE=3, RECOVER=4.
- IDLE -> MOVE on the first clock with enable=1.
- MOVE, on each tick:
  - If lane_req < NUM_LANES, lane <= lane_req; otherwise lane is unchanged.
  - move_cnt++.
  - When move_cnt reaches the limit (MOVES_N, or max(MOVES_N/2, 1) with aggressive), move_cnt clears and the FSM goes to WINDUP.
  - aggressive is sampled on each tick.
- WINDUP: lane is frozen. After WINDUP_TICKS ticks -> STRIKE.
- STRIKE:
  - attack_out=1 for exactly STRIKE_CYC clock cycles, counted on clocks, not ticks.
  - STRIKE always completes once entered, even if enable drops.
  - blocked_flag is set if block_in=1 on any STRIKE cycle.
  - On the cycle after the last strike cycle: exactly one of blocked_pulse (flag=1) or hit_pulse (flag=0) pulses; attack_out falls; blocked_flag clears; FSM -> RECOVER.
- RECOVER: next tick -> MOVE.

Outputs and timing:
- x_out = X_BASE + lane*X_STEP, registered. It updates on the clock after the lane changes (1-cycle latency from tick).
- y_out = Y_POS at all times.
- enable=0 outside STRIKE holds the FSM in its current state; all counters hold.
- Reset asserted mid-STRIKE: attack_out drops immediately (asynchronously) and no hit or blocked pulse is issued.

Test Plan (SLOW_DIV=4, FAST_DIV=2, MOVES_N=4, WINDUP_TICKS=2, STRIKE_CYC=8, NUM_LANES=3):
1. Reset release, enable=1, speed=0 -> tick every 4 clocks; state_out 0→1; x_out=20 until the first tick.
2. lane_req sequence 2, 1, 3, 0 on successive ticks -> x_out 100, 60, 60 (3 rejected), 20; WINDUP entered on the 4th tick.
3. aggressive=1 -> WINDUP after 2 ticks. speed toggled to 1 mid-count -> the current 4-clock period finishes, then ticks every 2 clocks.
4. block_in low throughout STRIKE -> attack_out high for 8 clocks, then one hit_pulse; no blocked_pulse.
5. block_in high for one cycle in STRIKE -> blocked_pulse only. enable=0 dropped mid-STRIKE -> the strike still completes, then the FSM freezes in RECOVER.
6. resetn pulsed low during STRIKE cycle 3 -> attack_out=0 asynchronously, x_out=20, state_out=0, no pulses.
